vocab_matcher: RTL and testbench
================================

// Module: vocab_matcher
// PURPOSE
//  Searches a vocabulary SRAM of TERM_CHAR-terminated words for the word held in an input SRAM.
//  Reports hit/miss, matching word index and word start address.
//  Successor to the single-mode matcher:
//   - start/busy/done handshake
//   - exact or prefix match mode
//   - parametrised terminator
//   - address wrap-around
//   - optional ASCII case folding
//  Sits between the two synchronous read-only SRAMs (1-cycle read latency) and the tensor_core control FSM.
// PARAMETERS
//  ADDR_WIDTH  4  address width of both SRAMs; pointers wrap modulo 2**ADDR_WIDTH
//  DATA_WIDTH  8  character width (>=8 when case folding is compiled in)
//  TERM_CHAR   0  word terminator value
//  IDX_WIDTH   ADDR_WIDTH  width of match_idx
// PORTS
//  clk               in   1           clock, all logic on rising edge
//  rst               in   1           asynchronous, active-high reset
//  start             in   1           begin search; sampled only while busy=0
//  mode_prefix       in   1           0 = exact match, 1 = input word is a prefix of a vocab word; latched at start
//  vocab_start_addr  in   ADDR_WIDTH  first vocab address; latched at start
//  vocab_end_addr    in   ADDR_WIDTH  last vocab address, inclusive; latched at start
//  input_start_addr  in   ADDR_WIDTH  first input character address; latched at start
//  rd_en             out  1           chip select to both SRAMs
//  addr_v            out  ADDR_WIDTH  vocab SRAM address
//  addr_i            out  ADDR_WIDTH  input SRAM address
//  val_vocab         in   DATA_WIDTH  vocab SRAM dout, valid 1 cycle after rd_en
//  val_input         in   DATA_WIDTH  input SRAM dout, valid 1 cycle after rd_en
//  busy              out  1           search in progress
//  done              out  1           search finished; held until next accepted start
//  found             out  1           hit flag; valid while done=1
//  match_idx         out  IDX_WIDTH   0-based index of matching word (valid when found=1)
//  match_addr        out  ADDR_WIDTH  start address of matching word (valid when found=1)
// BEHAVIOUR
//  Reset:
//   - All outputs are 0; state is IDLE.
//   - Reset mid-search aborts immediately; no partial result survives.
//  Internal registers:
//   - av: vocab pointer; ai: input pointer; ws: current word start; idx: word counter.
//  IDLE:
//   - On start, load av=ws=vocab_start_addr, ai=input_start_addr, idx=0.
//   - Clear done and found, set busy, go to RD.
//  RD:
//   - rd_en=1, addr_v=av, addr_i=ai; go to CMP.
//   - Each character compare therefore costs 2 cycles.
//  CMP (v, i = sampled SRAM data, after the optional fold). First matching rule wins:
//   a) i==TERM and (v==TERM or mode_prefix): HIT.
//   b) v==i: if av==end, MISS; else av++, ai++, go to RD.
//   c) v==TERM (word ended early): if av==end, MISS; else NEXT.
//   d) otherwise: if av==end, MISS; else av++, go to SK_RD.
//  SK_RD / SK_CMP (skip the rest of a failed word):
//   - SK_RD reads av.
//   - In SK_CMP: if v==TERM, NEXT; else if av==end, MISS; else av++, go to SK_RD.
//  NEXT:
//   - ws=av+1, av=av+1, ai=input_start_addr, idx++, go to RD.
//  HIT:
//   - found=1, match_idx=idx, match_addr=ws, done=1, busy=0, go to IDLE.
//  MISS:
//   - found=0, done=1, busy=0, go to IDLE.
//  Boundary cases:
//   - end < start: pointers wrap modulo 2**ADDR_WIDTH until av==end.
//   - end == start: exactly one vocab character is examined.
//   - start while busy=1 is ignored. start in the same cycle as rst: rst wins.
//   - Empty input word: matches the first empty vocab word in exact mode; matches word 0 in prefix mode.
//   - A vocab word cut off by end_addr without a terminator can still HIT in prefix mode only.
//   - idx wraps modulo 2**IDX_WIDTH.
//  Outputs addr_v, addr_i and rd_en are registered-state decodes, free of glitches from SRAM data.
// CONFIGURATION
//  MATCHER_CASE_FOLD_EN:
//   - Defined: bytes 'A'..'Z' (0x41-0x5A) in the low 8 bits of both v and i are mapped to lowercase (+0x20) before every compare.
//   - TERM detection uses the raw, unfolded value.
//   - Undefined: plain bitwise equality; no folding logic is generated.
// STRUCTURE
//  matcher_pkg:
//   - state enum: IDLE, RD, CMP, SK_RD, SK_CMP
//   - fold_char() function
//   - default TERM_CHAR constant
//  One sub-module, matcher_char_cmp (combinational):
//   - inputs: v, i, TERM_CHAR
//   - outputs: eq, v_term, i_term
//   - contains the MATCHER_CASE_FOLD_EN logic.
// TESTING
//  Common setup: vocab SRAM = "cat\0dog\0cow\0" at 0..11, rest 0; vocab 0..15.
//  1. input "dog\0", exact -> done=1, found=1, match_idx=1, match_addr=4; busy high from the cycle after start until done.
//  2. input "cab\0", exact -> done=1, found=0; the last address read is 15.
//  3. input "co\0", prefix -> found=1, match_idx=2, match_addr=8.
//     Same input, exact -> found=0.
//  4. input "DOG\0", exact -> with MATCHER_CASE_FOLD_EN: found=1, match_idx=1; without it: found=0.
//  5. rst pulsed while in SK_CMP -> all outputs 0 asynchronously; a fresh start with "cow\0" then gives match_idx=2.
//  6. start re-pulsed while busy -> ignored, result identical to scenario 1.
//     vocab_start=12, end=3 with "cat\0" at 0..3 -> pointers wrap, found=1, match_addr=0.

Source files
------------

// File: rtl/matcher_pkg.sv
// Shared types and helpers for the vocabulary matcher.
// Holds the FSM state enum, the per-compare action enum, the default
// terminator value and the ASCII case-folding helper.
package matcher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CMP,
        SK_RD,
        SK_CMP
    } state_t;

    // Outcome of one compare cycle (CMP or SK_CMP)
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_HIT,
        ACT_MISS,
        ACT_STEP,
        ACT_SKIP,
        ACT_NEXT
    } act_t;

    localparam int DEF_TERM_CHAR = 0;

    // Map 'A'..'Z' to 'a'..'z'; every other byte passes through
    function automatic logic [7:0] fold_char(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A) begin
            return c + 8'h20;
        end
        return c;
    endfunction

endpackage

// File: rtl/matcher_char_cmp.sv
// Combinational character comparator for the vocabulary matcher.
// Ports: v, i (SRAM characters) in; eq (after optional fold), v_term, i_term out.
// Macro MATCHER_CASE_FOLD_EN: when defined, the low byte of both characters
// is folded to lowercase before the equality test. Terminator detection
// always uses the raw characters.
module matcher_char_cmp
    import matcher_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TERM_CHAR  = DEF_TERM_CHAR
) (
    input  logic [DATA_WIDTH-1:0] v,
    input  logic [DATA_WIDTH-1:0] i,
    output logic                  eq,
    output logic                  v_term,
    output logic                  i_term
);

    localparam logic [DATA_WIDTH-1:0] TERM = DATA_WIDTH'(TERM_CHAR);

    assign v_term = (v == TERM);
    assign i_term = (i == TERM);

`ifdef MATCHER_CASE_FOLD_EN
    logic [DATA_WIDTH-1:0] v_fold;
    logic [DATA_WIDTH-1:0] i_fold;

    always_comb begin
        v_fold      = v;
        i_fold      = i;
        v_fold[7:0] = fold_char(v[7:0]);
        i_fold[7:0] = fold_char(i[7:0]);
    end

    assign eq = (v_fold == i_fold);
`else
    assign eq = (v == i);
`endif

endmodule

// File: rtl/vocab_matcher.sv
// Searches a vocabulary SRAM of terminated words for the word in an input SRAM.
// Ports: clk, rst (async high), start/mode_prefix/vocab_start_addr/vocab_end_addr/
// input_start_addr in; rd_en/addr_v/addr_i out to both SRAMs; val_vocab/val_input in;
// busy/done/found/match_idx/match_addr result outputs.
// Macro MATCHER_CASE_FOLD_EN enables ASCII case-insensitive compares.
module vocab_matcher
    import matcher_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TERM_CHAR  = DEF_TERM_CHAR,
    parameter int IDX_WIDTH  = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode_prefix,
    input  logic [ADDR_WIDTH-1:0] vocab_start_addr,
    input  logic [ADDR_WIDTH-1:0] vocab_end_addr,
    input  logic [ADDR_WIDTH-1:0] input_start_addr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] addr_v,
    output logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] val_vocab,
    input  logic [DATA_WIDTH-1:0] val_input,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [IDX_WIDTH-1:0]  match_idx,
    output logic [ADDR_WIDTH-1:0] match_addr
);

    state_t                state;
    act_t                  act;
    logic [ADDR_WIDTH-1:0] av;
    logic [ADDR_WIDTH-1:0] ai;
    logic [ADDR_WIDTH-1:0] ws;
    logic [ADDR_WIDTH-1:0] end_r;
    logic [ADDR_WIDTH-1:0] in_start_r;
    logic [IDX_WIDTH-1:0]  idx;
    logic                  mode_r;
    logic                  eq;
    logic                  v_term;
    logic                  i_term;
    logic                  last;

    matcher_char_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .TERM_CHAR  (TERM_CHAR)
    ) u_cmp (
        .v      (val_vocab),
        .i      (val_input),
        .eq     (eq),
        .v_term (v_term),
        .i_term (i_term)
    );

    // Read strobe and addresses come straight from registered state only
    assign rd_en  = (state == RD) || (state == SK_RD);
    assign addr_v = av;
    assign addr_i = ai;
    assign last   = (av == end_r);

    always_comb begin
        act = ACT_NONE;
        unique case (state)
            CMP: begin
                if (i_term && (v_term || mode_r)) begin
                    act = ACT_HIT;
                end else if (eq) begin
                    act = last ? ACT_MISS : ACT_STEP;
                end else if (v_term) begin
                    act = last ? ACT_MISS : ACT_NEXT;
                end else begin
                    act = last ? ACT_MISS : ACT_SKIP;
                end
            end
            SK_CMP: begin
                // A terminator ends the skipped word even on the end address
                if (v_term) begin
                    act = ACT_NEXT;
                end else begin
                    act = last ? ACT_MISS : ACT_SKIP;
                end
            end
            default: act = ACT_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            av         <= '0;
            ai         <= '0;
            ws         <= '0;
            end_r      <= '0;
            in_start_r <= '0;
            idx        <= '0;
            mode_r     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            match_idx  <= '0;
            match_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        av         <= vocab_start_addr;
                        ws         <= vocab_start_addr;
                        ai         <= input_start_addr;
                        in_start_r <= input_start_addr;
                        end_r      <= vocab_end_addr;
                        mode_r     <= mode_prefix;
                        idx        <= '0;
                        done       <= 1'b0;
                        found      <= 1'b0;
                        busy       <= 1'b1;
                        state      <= RD;
                    end
                end
                RD:    state <= CMP;
                SK_RD: state <= SK_CMP;
                CMP, SK_CMP: begin
                    unique case (act)
                        ACT_HIT: begin
                            found      <= 1'b1;
                            match_idx  <= idx;
                            match_addr <= ws;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                        ACT_MISS: begin
                            found <= 1'b0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                        ACT_STEP: begin
                            av    <= av + 1'b1;
                            ai    <= ai + 1'b1;
                            state <= RD;
                        end
                        ACT_SKIP: begin
                            av    <= av + 1'b1;
                            state <= SK_RD;
                        end
                        ACT_NEXT: begin
                            ws    <= av + 1'b1;
                            av    <= av + 1'b1;
                            ai    <= in_start_r;
                            idx   <= idx + 1'b1;
                            state <= RD;
                        end
                        default: state <= IDLE;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vocab_matcher.sv
// Self-checking bench for vocab_matcher with behavioural 1-cycle SRAMs.
// Expected results are queued at each start and compared when done rises.
module tb_vocab_matcher;
    import matcher_pkg::*;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
        logic [3:0] addr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mode_prefix;
    logic [3:0] vocab_start_addr;
    logic [3:0] vocab_end_addr;
    logic [3:0] input_start_addr;
    logic       rd_en;
    logic [3:0] addr_v;
    logic [3:0] addr_i;
    logic [7:0] val_vocab;
    logic [7:0] val_input;
    logic       busy;
    logic       done;
    logic       found;
    logic [3:0] match_idx;
    logic [3:0] match_addr;

    logic [7:0] vmem [16];
    logic [7:0] imem [16];
    logic [3:0] last_av;
    exp_t       sb [$];
    bit         busy_ok;
    int         checks;
    int         errors;

    vocab_matcher dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .mode_prefix      (mode_prefix),
        .vocab_start_addr (vocab_start_addr),
        .vocab_end_addr   (vocab_end_addr),
        .input_start_addr (input_start_addr),
        .rd_en            (rd_en),
        .addr_v           (addr_v),
        .addr_i           (addr_i),
        .val_vocab        (val_vocab),
        .val_input        (val_input),
        .busy             (busy),
        .done             (done),
        .found            (found),
        .match_idx        (match_idx),
        .match_addr       (match_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            val_vocab <= vmem[addr_v];
            val_input <= imem[addr_i];
            last_av   <= addr_v;
        end
    end

    task automatic load_input(input string s);
        for (int k = 0; k < 16; k++) imem[k] = 8'h00;
        for (int k = 0; k < s.len(); k++) imem[k] = s[k];
    endtask

    task automatic do_search(
        input  logic       mp,
        input  logic [3:0] vs,
        input  logic [3:0] ve,
        input  logic       ef,
        input  logic [3:0] ei,
        input  logic [3:0] ea,
        input  bit         repulse,
        output bit         to
    );
        exp_t e;
        e.found = ef;
        e.idx   = ei;
        e.addr  = ea;
        sb.push_back(e);
        @(negedge clk);
        mode_prefix      = mp;
        vocab_start_addr = vs;
        vocab_end_addr   = ve;
        input_start_addr = 4'd0;
        start            = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        busy_ok = (busy === 1'b1) && (done === 1'b0);
        to      = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (done === 1'b1) begin
                to = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (repulse && c == 3) begin
                start            = 1'b1;
                vocab_start_addr = 4'd8;
            end
            if (repulse && c == 4) begin
                start            = 1'b0;
                vocab_start_addr = vs;
            end
            @(negedge clk);
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({rd_en, addr_v, addr_i, busy, done, found, match_idx, match_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0",
                {rd_en, addr_v, addr_i, busy, done, found, match_idx, match_addr});
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL start_with_rst got busy=%b rd_en=%b want 0 0", busy, rd_en);
        end
    endtask

    task automatic test_exact_hit();
        bit   to;
        exp_t e;
        load_input("dog");
        do_search(1'b0, 4'd0, 4'd15, 1'b1, 4'd1, 4'd4, 1'b0, to);
        e = sb.pop_front();
        checks++;
        if (to || {done, found, match_idx, match_addr} !== {1'b1, e.found, e.idx, e.addr}) begin
            errors++;
            $display("FAIL exact_dog got d=%b f=%b idx=%0d addr=%0d want f=%b idx=%0d addr=%0d",
                done, found, match_idx, match_addr, e.found, e.idx, e.addr);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL busy_window got busy not held until done want held");
        end
    endtask

    task automatic test_miss();
        bit   to;
        exp_t e;
        load_input("cab");
        do_search(1'b0, 4'd0, 4'd15, 1'b0, 4'd0, 4'd0, 1'b0, to);
        e = sb.pop_front();
        checks++;
        if (to || {done, found} !== {1'b1, e.found}) begin
            errors++;
            $display("FAIL miss_cab got d=%b f=%b want d=1 f=%b", done, found, e.found);
        end
        checks++;
        if (last_av !== 4'd15) begin
            errors++;
            $display("FAIL miss_last_addr got %0d want 15", last_av);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_held got d=%b b=%b want 1 0", done, busy);
        end
    endtask

    task automatic test_prefix();
        bit   to;
        exp_t e;
        load_input("co");
        do_search(1'b1, 4'd0, 4'd15, 1'b1, 4'd2, 4'd8, 1'b0, to);
        e = sb.pop_front();
        checks++;
        if (to || {done, found, match_idx, match_addr} !== {1'b1, e.found, e.idx, e.addr}) begin
            errors++;
            $display("FAIL prefix_co got f=%b idx=%0d addr=%0d want f=%b idx=%0d addr=%0d",
                found, match_idx, match_addr, e.found, e.idx, e.addr);
        end
        do_search(1'b0, 4'd0, 4'd15, 1'b0, 4'd0, 4'd0, 1'b0, to);
        e = sb.pop_front();
        checks++;
        if (to || {done, found} !== {1'b1, e.found}) begin
            errors++;
            $display("FAIL exact_co got d=%b f=%b want d=1 f=%b", done, found, e.found);
        end
    endtask

    task automatic test_case_fold();
        bit   to;
        exp_t e;
        load_input("DOG");
`ifdef MATCHER_CASE_FOLD_EN
        do_search(1'b0, 4'd0, 4'd15, 1'b1, 4'd1, 4'd4, 1'b0, to);
        e = sb.pop_front();
        checks++;
        if (to || {done, found, match_idx} !== {1'b1, e.found, e.idx}) begin
            errors++;
            $display("FAIL fold_DOG got f=%b idx=%0d want f=%b idx=%0d",
                found, match_idx, e.found, e.idx);
        end
`else
        do_search(1'b0, 4'd0, 4'd15, 1'b0, 4'd0, 4'd0, 1'b0, to);
        e = sb.pop_front();
        checks++;
        if (to || {done, found} !== {1'b1, e.found}) begin
            errors++;
            $display("FAIL nofold_DOG got d=%b f=%b want d=1 f=%b", done, found, e.found);
        end
`endif
    endtask

    task automatic test_empty_input();
        bit   to;
        exp_t e;
        load_input("");
        do_search(1'b0, 4'd0, 4'd15, 1'b1, 4'd3, 4'd12, 1'b0, to);
        e = sb.pop_front();
        checks++;
        if (to || {done, found, match_idx, match_addr} !== {1'b1, e.found, e.idx, e.addr}) begin
            errors++;
            $display("FAIL empty_exact got f=%b idx=%0d addr=%0d want f=%b idx=%0d addr=%0d",
                found, match_idx, match_addr, e.found, e.idx, e.addr);
        end
        do_search(1'b1, 4'd0, 4'd15, 1'b1, 4'd0, 4'd0, 1'b0, to);
        e = sb.pop_front();
        checks++;
        if (to || {done, found, match_idx, match_addr} !== {1'b1, e.found, e.idx, e.addr}) begin
            errors++;
            $display("FAIL empty_prefix got f=%b idx=%0d addr=%0d want f=%b idx=%0d addr=%0d",
                found, match_idx, match_addr, e.found, e.idx, e.addr);
        end
    endtask

    task automatic test_bounds();
        bit   to;
        exp_t e;
        load_input("d");
        do_search(1'b0, 4'd4, 4'd4, 1'b0, 4'd0, 4'd0, 1'b0, to);
        e = sb.pop_front();
        checks++;
        if (to || {done, found} !== {1'b1, e.found} || last_av !== 4'd4) begin
            errors++;
            $display("FAIL single_char got f=%b last=%0d want f=%b last=4",
                found, last_av, e.found);
        end
        do_search(1'b1, 4'd4, 4'd5, 1'b1, 4'd0, 4'd4, 1'b0, to);
        e = sb.pop_front();
        checks++;
        if (to || {done, found, match_idx, match_addr} !== {1'b1, e.found, e.idx, e.addr}) begin
            errors++;
            $display("FAIL cutoff_prefix got f=%b idx=%0d addr=%0d want f=%b idx=%0d addr=%0d",
                found, match_idx, match_addr, e.found, e.idx, e.addr);
        end
        do_search(1'b0, 4'd4, 4'd5, 1'b0, 4'd0, 4'd0, 1'b0, to);
        e = sb.pop_front();
        checks++;
        if (to || {done, found} !== {1'b1, e.found}) begin
            errors++;
            $display("FAIL cutoff_exact got d=%b f=%b want d=1 f=%b", done, found, e.found);
        end
    endtask

    task automatic test_reset_abort();
        bit   to;
        bit   hit;
        exp_t e;
        load_input("cow");
        @(negedge clk);
        mode_prefix      = 1'b0;
        vocab_start_addr = 4'd0;
        vocab_end_addr   = 4'd15;
        input_start_addr = 4'd0;
        start            = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit   = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (dut.state == SK_CMP) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit || busy !== 1'b1) begin
            errors++;
            $display("FAIL reach_sk_cmp got reached=%b busy=%b want 1 1", hit, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rd_en, addr_v, addr_i, busy, done, found, match_idx, match_addr} !== '0) begin
            errors++;
            $display("FAIL async_abort got %b want 0",
                {rd_en, addr_v, addr_i, busy, done, found, match_idx, match_addr});
        end
        @(negedge clk);
        rst = 1'b0;
        do_search(1'b0, 4'd0, 4'd15, 1'b1, 4'd2, 4'd8, 1'b0, to);
        e = sb.pop_front();
        checks++;
        if (to || {done, found, match_idx, match_addr} !== {1'b1, e.found, e.idx, e.addr}) begin
            errors++;
            $display("FAIL after_abort_cow got f=%b idx=%0d addr=%0d want f=%b idx=%0d addr=%0d",
                found, match_idx, match_addr, e.found, e.idx, e.addr);
        end
    endtask

    task automatic test_back_to_back();
        bit   to;
        exp_t e;
        load_input("dog");
        do_search(1'b0, 4'd0, 4'd15, 1'b1, 4'd1, 4'd4, 1'b1, to);
        e = sb.pop_front();
        checks++;
        if (to || {done, found, match_idx, match_addr} !== {1'b1, e.found, e.idx, e.addr}) begin
            errors++;
            $display("FAIL restart_ignored got f=%b idx=%0d addr=%0d want f=%b idx=%0d addr=%0d",
                found, match_idx, match_addr, e.found, e.idx, e.addr);
        end
    endtask

    task automatic test_wrap();
        bit   to;
        exp_t e;
        load_input("cat");
        do_search(1'b0, 4'd12, 4'd3, 1'b1, 4'd4, 4'd0, 1'b0, to);
        e = sb.pop_front();
        checks++;
        if (to || {done, found, match_idx, match_addr} !== {1'b1, e.found, e.idx, e.addr}) begin
            errors++;
            $display("FAIL wrap_cat got f=%b idx=%0d addr=%0d want f=%b idx=%0d addr=%0d",
                found, match_idx, match_addr, e.found, e.idx, e.addr);
        end
    endtask

    initial begin
        string voc;
        checks           = 0;
        errors           = 0;
        start            = 1'b0;
        mode_prefix      = 1'b0;
        vocab_start_addr = 4'd0;
        vocab_end_addr   = 4'd15;
        input_start_addr = 4'd0;
        val_vocab        = 8'h00;
        val_input        = 8'h00;
        last_av          = 4'd0;
        voc              = "cat dog cow ";
        for (int k = 0; k < 16; k++) vmem[k] = 8'h00;
        for (int k = 0; k < voc.len(); k++) begin
            vmem[k] = (voc[k] == 8'h20) ? 8'h00 : voc[k];
        end
        load_input("");
        test_reset();
        test_exact_hit();
        test_miss();
        test_prefix();
        test_case_fold();
        test_empty_input();
        test_bounds();
        test_reset_abort();
        test_back_to_back();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
